// File: rtl/spi_cmd_master.sv
// spi_cmd_master
//   Single-clock SPI master (mode 0, MSB first) for the 32-bit command/data
//   SPI slave. One transaction = one SS-low burst of two frames:
//   {24'h0, cmd} followed by the data frame (wdata for writes, MISO capture
//   for reads), then a few SCLK pulses with SS high so the slave returns to
//   idle.
//
// Ports
//   clk    system clock, rising edge
//   reset  synchronous, active-low
//   start  request a transaction (sampled only while idle)
//   cmd    1=wr DIN, 2=wr ADDR, 3=wr MISC, 4=rd MISC, 5=rd DOUT
//   wdata  write payload
//   busy   transaction in progress (through the done cycle)
//   done   one-cycle completion pulse
//   err    valid with done; unsupported cmd, no SPI activity took place
//   rdata  last read result (only cmd 4/5 update it)
//   SS     slave select, active low
//   SCLK   serial clock, idles low
//   MOSI   master out
//   MISO   slave out
module spi_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 4,
  parameter int TRAIL_CLKS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            cmd,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  SS,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TRW  = (TRAIL_CLKS > 1) ? $clog2(TRAIL_CLKS) : 1;
  localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(CLK_DIV - 1);
  localparam logic [TRW-1:0]  TRAIL_LAST = TRW'(TRAIL_CLKS - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, HOLD, TRAIL, DONE} state_t;

  state_t                  state_q;
  logic [DIVW-1:0]         div_q;
  logic [TRW-1:0]          trail_q;
  logic [6:0]              edge_q;    // SCLK rising edges issued in SHIFT
  logic [2*DATA_WIDTH-1:0] sh_q;
  logic [DATA_WIDTH-1:0]   rx_q;
  logic                    rd_q;
  logic                    ss_q, sclk_q, mosi_q, busy_q, done_q, err_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic                    cmd_ok, cmd_rd, half_end;
  logic [2*DATA_WIDTH-1:0] lead_word;
  logic [DIVW-1:0]         div_d;

  assign cmd_ok   = (cmd >= 8'd1) && (cmd <= 8'd5);
  assign cmd_rd   = (cmd == 8'd4) || (cmd == 8'd5);
  assign half_end = (div_q == DIV_LAST);
  assign div_d    = half_end ? '0 : div_q + 1'b1;
  // Read commands send an all-zero data frame.
  assign lead_word = {{(DATA_WIDTH-8){1'b0}}, cmd,
                      (cmd_rd ? {DATA_WIDTH{1'b0}} : wdata)};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      trail_q <= '0;
      edge_q  <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      rd_q    <= 1'b0;
      ss_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            rd_q    <= cmd_rd;
            div_q   <= '0;
            edge_q  <= '0;
            trail_q <= '0;
            if (cmd_ok) begin
              state_q <= LEAD;
              ss_q    <= 1'b0;
              sh_q    <= lead_word;
              mosi_q  <= lead_word[2*DATA_WIDTH-1];
            end else begin
              // Unsupported command: report straight away, bus untouched.
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end

        LEAD: begin
          div_q <= div_d;
          if (half_end) begin
            state_q <= SHIFT;
            sclk_q  <= 1'b1;
            edge_q  <= 7'd1;
          end
        end

        SHIFT: begin
          div_q <= div_d;
          if (half_end) begin
            if (sclk_q) begin
              // Falling edge: advance MOSI; slave drove MISO on the last rise.
              sclk_q <= 1'b0;
              sh_q   <= sh_q << 1;
              mosi_q <= sh_q[2*DATA_WIDTH-2];
              if (rd_q && (edge_q >= 7'd33))
                rx_q <= {rx_q[DATA_WIDTH-2:0], MISO};
            end else if (edge_q == 7'd64) begin
              state_q <= HOLD;
            end else begin
              sclk_q <= 1'b1;
              edge_q <= edge_q + 7'd1;
            end
          end
        end

        HOLD: begin
          div_q <= div_d;
          if (half_end) begin
            state_q <= TRAIL;
            ss_q    <= 1'b1;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
            trail_q <= '0;
          end
        end

        TRAIL: begin
          div_q <= div_d;
          if (half_end) begin
            if (sclk_q) begin
              sclk_q <= 1'b0;
            end else if (trail_q == TRAIL_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
              if (rd_q)
                rdata_q <= rx_q;
            end else begin
              sclk_q  <= 1'b1;
              trail_q <= trail_q + 1'b1;
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign SS    = ss_q;
  assign SCLK  = sclk_q;
  assign MOSI  = mosi_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
module tb_spi_cmd_master;

  localparam int DW  = 32;
  localparam int CD  = 4;
  localparam int TC  = 2;
  localparam int LAT = 1 + CD * (130 + 2 * TC);   // 537 at defaults

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    cmd   = 8'h00;
  logic [DW-1:0] wdata = '0;
  logic          busy, done, err, SS, SCLK, MOSI, MISO;
  logic [DW-1:0] rdata;

  spi_cmd_master #(.DATA_WIDTH(DW), .CLK_DIV(CD), .TRAIL_CLKS(TC)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // cycle counter and done monitor
  int   cyc      = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic done_err = 1'b0;
  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      done_err = err;
    end
  end

  // SCLK edge / SS activity counters
  int rise_lo = 0, rise_hi = 0, ss_fall = 0;
  always @(posedge SCLK) begin
    if (SS) rise_hi = rise_hi + 1;
    else    rise_lo = rise_lo + 1;
  end
  always @(negedge SS) ss_fall = ss_fall + 1;

  // behavioural model of the command/data SPI slave
  logic [31:0] s_din = '0, s_addr = '0, s_misc = '0;
  logic [31:0] s_dout = 32'h8000_0001;
  logic [63:0] s_sh = '0, s_frame = '0;
  logic [7:0]  s_cmd = '0;
  logic        s_miso = 1'b0;
  int          s_bcnt = 0;
  assign MISO = s_miso;

  always @(posedge SCLK or posedge SS) begin
    if (SS) begin
      if (s_bcnt == 64) begin
        s_frame = s_sh;
        case (s_sh[39:32])
          8'd1: s_din  = s_sh[31:0];
          8'd2: s_addr = s_sh[31:0];
          8'd3: s_misc = s_sh[31:0];
          default: ;
        endcase
      end
      s_bcnt = 0;
      s_miso = 1'b0;
    end else begin
      s_sh   = {s_sh[62:0], MOSI};
      s_bcnt = s_bcnt + 1;
      if (s_bcnt == 32) s_cmd = s_sh[7:0];
      if (s_bcnt >= 33 && s_bcnt <= 64) begin
        if (s_cmd == 8'd4)      s_miso = s_misc[64 - s_bcnt];
        else if (s_cmd == 8'd5) s_miso = s_dout[64 - s_bcnt];
        else                    s_miso = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [7:0] c, input logic [31:0] d, output int a);
    @(negedge clk);
    cmd = c; wdata = d; start = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int a, input int n0, output int lat);
    for (int i = 0; i < 2000 && done_cnt == n0; i++) @(negedge clk);
    chk("done_seen", 64'(done_cnt - n0), 64'd1);
    lat = (done_cnt == n0) ? -1 : (done_cyc - a + 1);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int a, lat, n0, lo0, hi0, sf0;
    logic [31:0] din0, addr0;

    vecs[0] = '{8'd3,  32'hA5A5_1234, 1'b0, 32'h0000_0000};
    vecs[1] = '{8'd4,  32'hFFFF_FFFF, 1'b0, 32'hA5A5_1234};
    vecs[2] = '{8'd1,  32'hDEAD_BEEF, 1'b0, 32'hA5A5_1234};
    vecs[3] = '{8'd5,  32'h0000_0000, 1'b0, 32'h8000_0001};
    vecs[4] = '{8'h07, 32'h1234_5678, 1'b1, 32'h8000_0001};
    vecs[5] = '{8'd2,  32'h0000_0123, 1'b0, 32'h8000_0001};
    vecs[6] = '{8'd0,  32'hFFFF_FFFF, 1'b1, 32'h8000_0001};
    vecs[7] = '{8'd4,  32'h0000_0000, 1'b0, 32'hA5A5_1234};

    // reset state
    repeat (4) @(negedge clk);
    chk("reset_ctrl", {58'd0, SS, SCLK, MOSI, busy, done, err}, 64'b100000);
    chk("reset_rdata", rdata, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven transactions
    for (int i = 0; i < 8; i++) begin
      lo0 = rise_lo; hi0 = rise_hi; sf0 = ss_fall; n0 = done_cnt;
      accept(vecs[i].cmd, vecs[i].wdata, a);
      wait_done(a, n0, lat);
      chk("latency", 64'(lat), vecs[i].exp_err ? 64'd1 : 64'(LAT));
      chk("err", done_err, vecs[i].exp_err);
      chk("rdata", rdata, vecs[i].exp_rdata);
      chk("sclk_ss_low", 64'(rise_lo - lo0), vecs[i].exp_err ? 64'd0 : 64'd64);
      chk("sclk_ss_high", 64'(rise_hi - hi0), vecs[i].exp_err ? 64'd0 : 64'(TC));
      chk("ss_fall", 64'(ss_fall - sf0), vecs[i].exp_err ? 64'd0 : 64'd1);
      case (vecs[i].cmd)
        8'd1: chk("slave_din",  s_din,  vecs[i].wdata);
        8'd2: chk("slave_addr", s_addr, vecs[i].wdata);
        8'd3: chk("slave_misc", s_misc, vecs[i].wdata);
        8'd4, 8'd5: begin
          chk("read_frame2_mosi", s_frame[31:0], 0);
          chk("read_cmd_frame", s_frame[63:32], {24'd0, vecs[i].cmd});
        end
        default: ;
      endcase
    end

    // start while busy is ignored
    addr0 = s_addr; n0 = done_cnt;
    accept(8'd1, 32'h1111_2222, a);
    while (cyc < a + 99) @(negedge clk);
    cmd = 8'd2; wdata = 32'h5555_AAAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(a, n0, lat);
    chk("busy_latency", 64'(lat), 64'(LAT));
    repeat (700) @(negedge clk);
    chk("busy_one_done", 64'(done_cnt - n0), 64'd1);
    chk("busy_addr_kept", s_addr, addr0);
    chk("busy_din", s_din, 32'h1111_2222);

    // reset in the middle of the shift phase
    din0 = s_din; n0 = done_cnt;
    accept(8'd1, 32'h0BAD_F00D, a);
    while (cyc < a + 199) @(negedge clk);
    chk("midshift_ss", SS, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ctrl", {58'd0, SS, SCLK, MOSI, busy, done, err}, 64'b100000);
    chk("abort_rdata", rdata, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (700) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - n0), 64'd0);
    chk("abort_din_kept", s_din, din0);
    n0 = done_cnt;
    accept(8'd4, 32'h0, a);
    wait_done(a, n0, lat);
    chk("post_reset_latency", 64'(lat), 64'(LAT));
    chk("post_reset_rdata", rdata, 32'hA5A5_1234);
    chk("post_reset_err", done_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
